// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: load-use stall, branch flush and EX forwarding selects over a DEPTH-entry writer table.
// Define HAZARD_FWD_EN for forwarding; otherwise the unit interlocks on every in-flight writer before WB.
module pipe_hazard_unit #(
  parameter int AW = 5,
  parameter int DEPTH = 3,
  parameter int LOAD_STAGE = 3,
  parameter int CNT_W = 16,
  localparam int FW = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_en,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic [AW-1:0]    id_wr_addr,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             flush,
  output logic [FW-1:0]    fwd_a,
  output logic [FW-1:0]    fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef struct packed {
    logic          v;
    logic          we;
    logic [AW-1:0] wa;
    logic          ld;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          urs;
    logic          urt;
  } ent_t;
`ifdef HAZARD_FWD_EN
  localparam int   LU = LOAD_STAGE - 2;
  localparam logic LD_ONLY = 1'b1;
`else
  localparam int   LU = DEPTH - 1;
  localparam logic LD_ONLY = 1'b0;
`endif
  ent_t             tab_q [1:DEPTH];
  ent_t             in_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ca, cb;
  function automatic logic hit(input ent_t e, input logic [AW-1:0] r);
    return e.v && e.we && (e.wa == r) && (r != '0);
  endfunction
  // Descending scans so the youngest (lowest s) match is the one that sticks.
  always_comb begin
    ca = 1'b0;
    cb = 1'b0;
    fwd_a = '0;
    fwd_b = '0;
    for (int s = DEPTH; s >= 1; s--) begin
      if (id_use_rs && hit(tab_q[s], id_rs)) ca = (tab_q[s].ld || !LD_ONLY) && (s <= LU);
      if (id_use_rt && hit(tab_q[s], id_rt)) cb = (tab_q[s].ld || !LD_ONLY) && (s <= LU);
    end
`ifdef HAZARD_FWD_EN
    for (int s = DEPTH; s >= 2; s--) begin
      if (tab_q[1].v && tab_q[1].urs && hit(tab_q[s], tab_q[1].rs)) fwd_a = FW'(s - 1);
      if (tab_q[1].v && tab_q[1].urt && hit(tab_q[s], tab_q[1].rt)) fwd_b = FW'(s - 1);
    end
`endif
    flush = pipe_en && ex_branch_taken;
    stall = pipe_en && !ex_branch_taken && (ca || cb);
    in_d = (id_valid && !stall && !flush) ?
           ent_t'{1'b1, id_wr_en, id_wr_addr, id_is_load, id_rs, id_rt, id_use_rs, id_use_rt} : '0;
    cnt_d = (stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 1; s <= DEPTH; s++) tab_q[s] <= '0;
      cnt_q <= '0;
    end else if (pipe_en) begin
      tab_q[1] <= in_d;
      for (int s = 2; s <= DEPTH; s++) tab_q[s] <= tab_q[s-1];
      cnt_q <= cnt_d;
    end
  end
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: table-driven per-cycle vectors checked through a scoreboard queue, plus reset-mid-stall.
module tb_pipe_hazard_unit;
  logic clk = 1'b0, rst = 1'b1, pipe_en = 1'b0, id_valid = 1'b0;
  logic id_use_rs = 1'b0, id_use_rt = 1'b0, id_wr_en = 1'b0, id_is_load = 1'b0, ex_branch_taken = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_wr_addr = '0;
  logic stall, flush;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  int checks = 0, failures = 0;
  typedef struct {
    logic pe, br, v, urs, urt, we, ld;
    logic [4:0] rs, rt, wa;
    logic xs, xfl;
    logic [1:0] xfa, xfb;
    logic [15:0] xc;
  } vec_t;
  typedef struct {
    logic xs, xfl;
    logic [1:0] xfa, xfb;
    logic [15:0] xc;
    int idx;
  } exp_t;
  vec_t tv[$];
  exp_t sb[$];
  always #5 clk = ~clk;
  pipe_hazard_unit dut (
    .clk(clk), .rst(rst), .pipe_en(pipe_en), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .stall(stall), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );
  function automatic vec_t ins(input logic v, urs, urt, we, ld, input logic [4:0] rs, rt, wa);
    vec_t t;
    t = '{default: '0};
    t.v = v; t.urs = urs; t.urt = urt; t.we = we; t.ld = ld; t.rs = rs; t.rt = rt; t.wa = wa;
    return t;
  endfunction
  function automatic vec_t alu(input logic [4:0] rs, rt, wa);
    return ins(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, rs, rt, wa);
  endfunction
  function automatic vec_t lw(input logic [4:0] rs, wa);
    return ins(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, rs, wa, wa);
  endfunction
  function automatic vec_t nop();
    return ins(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endfunction
  function automatic vec_t rw(input vec_t i, input logic pe, br, xs, xfl, input logic [1:0] fa, fb, input logic [15:0] c);
    vec_t t;
    t = i;
    t.pe = pe; t.br = br; t.xs = xs; t.xfl = xfl; t.xfa = fa; t.xfb = fb; t.xc = c;
    return t;
  endfunction
  task automatic drive(input vec_t t);
    pipe_en = t.pe; ex_branch_taken = t.br; id_valid = t.v;
    id_use_rs = t.urs; id_use_rt = t.urt; id_wr_en = t.we; id_is_load = t.ld;
    id_rs = t.rs; id_rt = t.rt; id_wr_addr = t.wa;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask
  initial begin
    exp_t e;
    repeat (2) @(negedge clk);
    #2;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset flush", 32'(flush), 32'd0);
    chk("reset fwd_a", 32'(fwd_a), 32'd0);
    chk("reset fwd_b", 32'(fwd_b), 32'd0);
    chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
`ifdef HAZARD_FWD_EN
    tv.push_back(rw(alu(1,2,3), 1,0,0,0, 0,0, 0));
    tv.push_back(rw(alu(3,5,4), 1,0,0,0, 0,0, 0));
    tv.push_back(rw(nop(),      1,0,0,0, 1,0, 0));
    tv.push_back(rw(nop(),      1,0,0,0, 0,0, 0));
    tv.push_back(rw(nop(),      1,0,0,0, 0,0, 0));
    tv.push_back(rw(lw(1,2),    1,0,0,0, 0,0, 0));
    tv.push_back(rw(alu(2,2,4), 1,0,1,0, 0,0, 0));
    tv.push_back(rw(alu(2,2,4), 1,0,0,0, 0,0, 1));
    tv.push_back(rw(nop(),      1,0,0,0, 2,2, 1));
    tv.push_back(rw(nop(),      1,0,0,0, 0,0, 1));
    tv.push_back(rw(nop(),      1,0,0,0, 0,0, 1));
    tv.push_back(rw(lw(1,7),    1,0,0,0, 0,0, 1));
    tv.push_back(rw(alu(7,7,6), 1,1,0,1, 0,0, 1));
    tv.push_back(rw(nop(),      1,0,0,0, 0,0, 1));
    tv.push_back(rw(nop(),      1,0,0,0, 0,0, 1));
    tv.push_back(rw(alu(1,2,0), 1,0,0,0, 0,0, 1));
    tv.push_back(rw(alu(0,0,6), 1,0,0,0, 0,0, 1));
    tv.push_back(rw(nop(),      1,0,0,0, 0,0, 1));
    tv.push_back(rw(lw(6,5),    1,0,0,0, 0,0, 1));
    tv.push_back(rw(alu(5,5,8), 0,1,0,0, 2,0, 1));
    tv.push_back(rw(alu(5,5,8), 0,0,0,0, 2,0, 1));
    tv.push_back(rw(alu(5,5,8), 1,0,1,0, 2,0, 1));
    tv.push_back(rw(alu(5,5,8), 1,0,0,0, 0,0, 2));
    tv.push_back(rw(nop(),      1,0,0,0, 2,2, 2));
`else
    tv.push_back(rw(alu(1,2,3), 1,0,0,0, 0,0, 0));
    tv.push_back(rw(alu(3,4,5), 1,0,1,0, 0,0, 0));
    tv.push_back(rw(alu(3,4,5), 1,0,1,0, 0,0, 1));
    tv.push_back(rw(alu(3,4,5), 1,0,0,0, 0,0, 2));
    tv.push_back(rw(nop(),      1,0,0,0, 0,0, 2));
    tv.push_back(rw(nop(),      1,0,0,0, 0,0, 2));
    tv.push_back(rw(alu(5,5,6), 1,0,0,0, 0,0, 2));
    tv.push_back(rw(lw(1,7),    1,0,0,0, 0,0, 2));
    tv.push_back(rw(alu(7,7,2), 1,1,0,1, 0,0, 2));
    tv.push_back(rw(alu(7,7,2), 1,0,1,0, 0,0, 2));
    tv.push_back(rw(alu(7,7,2), 1,0,0,0, 0,0, 3));
    tv.push_back(rw(alu(1,3,0), 1,0,0,0, 0,0, 3));
    tv.push_back(rw(alu(0,0,6), 1,0,0,0, 0,0, 3));
    tv.push_back(rw(alu(6,6,1), 0,1,0,0, 0,0, 3));
    tv.push_back(rw(alu(6,6,1), 1,0,1,0, 0,0, 3));
    tv.push_back(rw(alu(6,6,1), 1,0,1,0, 0,0, 4));
    tv.push_back(rw(alu(6,6,1), 1,0,0,0, 0,0, 5));
`endif
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i]);
      sb.push_back('{tv[i].xs, tv[i].xfl, tv[i].xfa, tv[i].xfb, tv[i].xc, i});
      #2;
      e = sb.pop_front();
      chk($sformatf("r%0d stall", e.idx), 32'(stall), 32'(e.xs));
      chk($sformatf("r%0d flush", e.idx), 32'(flush), 32'(e.xfl));
      chk($sformatf("r%0d fwd_a", e.idx), 32'(fwd_a), 32'(e.xfa));
      chk($sformatf("r%0d fwd_b", e.idx), 32'(fwd_b), 32'(e.xfb));
      chk($sformatf("r%0d stall_cnt", e.idx), 32'(stall_cnt), 32'(e.xc));
    end
    @(negedge clk);
    drive(rw(lw(9,2), 1,0,0,0, 0,0, 0));
    #2;
    chk("rst-seq lw stall", 32'(stall), 32'd0);
    @(negedge clk);
    drive(rw(alu(2,2,4), 1,0,0,0, 0,0, 0));
    #2;
    chk("rst-seq dep stall", 32'(stall), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst-seq async stall", 32'(stall), 32'd0);
    chk("rst-seq async flush", 32'(flush), 32'd0);
    chk("rst-seq async stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst-seq empty stall", 32'(stall), 32'd0);
    chk("rst-seq empty fwd_a", 32'(fwd_a), 32'd0);
    chk("rst-seq empty stall_cnt", 32'(stall_cnt), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard-detection and forwarding controller for the pipelined MIPS core. Sits beside the ID stage and tracks every in-flight register writer from EX through WB in an internal shift table. Generates the load-use stall, the branch flush, and per-operand forwarding selects for the EX-stage ALU inputs. Pipeline depth and load-data latency are parameters.

## Interface
- AW, 5, register address width
- DEPTH, 3, tracked stages after ID (1 = EX … DEPTH = WB); legal ≥2
- LOAD_STAGE, 3, first stage whose entry can forward load data; legal 2..DEPTH
- CNT_W, 16, stall counter width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pipe_en  in  1  global advance; low freezes table and counter
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  AW  ID source addresses
- id_use_rs, id_use_rt  in  1  source actually read
- id_wr_en  in  1  ID instruction writes a register
- id_wr_addr  in  AW  ID destination (already muxed by RegDst)
- id_is_load  in  1  ID instruction is LW
- ex_branch_taken  in  1  branch in EX resolved taken
- stall  out  1  hold PC and IF/ID; bubble into EX
- flush  out  1  squash IF/ID contents
- fwd_a, fwd_b  out  max(1,$clog2(DEPTH))  EX operand source: 0 = ID/EX value, k = result of stage k+1
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- Table entry s (1..DEPTH) holds {valid, wr_en, wr_addr, is_load, rs, rt, use_rs, use_rt} of the instruction in stage s.
- On each clk edge with pipe_en=1: entries shift s→s+1; entry DEPTH drops. Entry 1 loads ID fields if id_valid & ~stall & ~flush, else a bubble (valid=0).
- Match(s, r): valid & wr_en & wr_addr==r & r≠0. Only the youngest (lowest s) match counts.
- Load-use stall: for each used ID source, youngest match at s with is_load and s ≤ LOAD_STAGE−2 → stall=1.
- Forwarding for EX (entry 1) operand rs/rt: youngest match among s=2..DEPTH → fwd = s−1; none, unused, or r=0 → fwd=0.
- Flush: ex_branch_taken=1 → flush=1 and stall forced 0 the same cycle; ID instruction not captured.
- pipe_en=0: table and stall_cnt hold; stall and flush forced 0; fwd outputs still reflect the frozen table.
- stall_cnt increments on every edge with stall=1 and pipe_en=1; saturates at all-ones.

## Timing
- stall, flush, fwd_a, fwd_b are combinational from inputs and table state, valid in the same cycle. No registered outputs other than stall_cnt.
- Load-use, default params: LW in EX, dependent instruction in ID → exactly one stall cycle. Next cycle the LW is in MEM, there is a bubble in EX, no stall. Following cycle fwd=2 (MEM/WB).
- ALU producer directly ahead: fwd=1, zero stalls.
- Reset: all table entries invalid; stall=0, flush=0, fwd_a=fwd_b=0, stall_cnt=0. Reset mid-stall drops the stall immediately (async).
- Simultaneous stall condition and ex_branch_taken: flush wins, entry 1 gets a bubble, stall_cnt not incremented.
- Writer to r0 never matches, never stalls, never forwards.

## Configuration
- HAZARD_FWD_EN defined: forwarding as above.
- Not defined: interlock-only. fwd_a=fwd_b=0 always. Any used ID source with a match at any s=1..DEPTH−1 stalls, regardless of is_load. The WB entry does not stall; the register file writes before it is read.

## Test plan
- ADD r3←r1,r2 then SUB r4←r3,r5 back-to-back (FWD_EN): stall=0 throughout; fwd_a=1 in SUB's EX cycle.
- LW r2,0(r1) then ADD r4←r2,r2: stall=1 for exactly one cycle; stall_cnt=1; ADD sees fwd_a=fwd_b=2 in EX.
- BEQ taken in EX while a LW-dependent instruction is in ID: flush=1, stall=0, entry 1 becomes a bubble, stall_cnt unchanged.
- ADD r0←r1,r2 then OR r6←r0,r0: stall=0, fwd_a=fwd_b=0.
- Without HAZARD_FWD_EN, ADD r3 then ADD using r3: stall=1 for 2 cycles (DEPTH=3), fwd outputs 0.
- Assert rst during a load-use stall: stall drops at once; stall_cnt=0; table empty after release.
